// File: rtl/pgr_stream_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pgr_stream_arb: packet-locked round-robin arbiter with registered output   |
// | stage and mid-packet stall watchdog.                        Rev 1.0        |
// +----------------------------------------------------------------------------+
module pgr_stream_arb #(
    parameter int N       = 2,
    parameter int W       = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int GW  = $clog2(N);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0]  LAST_ID  = GW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]     state;
    logic [GW-1:0]  rr_ptr;
    logic [WDW-1:0] wd_cnt;
    logic           ld;
    logic           xfer;
    logic           wd_fire;
    logic [GW-1:0]  pick_id;
    logic [GW-1:0]  next_ptr;
    logic [W-1:0]   sel_data;

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int unsigned k);
        logic [GW:0] s;
        s = {1'b0, a} + (GW+1)'(k);
        if (s >= (GW+1)'(N)) s = s - (GW+1)'(N);
        return s[GW-1:0];
    endfunction

    assign ld       = ~out_valid | out_ready;
    assign xfer     = req_valid[grant_id] & req_ready[grant_id];
    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign sel_data = req_data[grant_id*W +: W];
    assign busy     = (state == S_LOCK);
    assign wd_fire  = (TIMEOUT > 0) && (state == S_LOCK) && !xfer && (wd_cnt == WD_LIMIT);

    always_comb begin
        req_ready = '0;
        if (state == S_LOCK && ld) req_ready[grant_id] = 1'b1;
    end

    // Scan from the farthest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        pick_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) pick_id = wrap_add(rr_ptr, k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            wd_cnt      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_fire;

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= req_last[grant_id];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick_id;
                        wd_cnt   <= '0;
                        state    <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (xfer) begin
                        wd_cnt <= '0;
                        if (req_last[grant_id]) begin
                            rr_ptr <= next_ptr;
                            state  <= S_IDLE;
                        end
                    end else if (wd_fire) begin
                        // Abandon the stalled packet; downstream sees it truncated.
                        wd_cnt <= '0;
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end else if (TIMEOUT > 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pgr_stream_arb.sv
`default_nettype none
// Directed bench for pgr_stream_arb: three instances cover the default
// arbitration path, a short watchdog and a four-way round robin.
module tb_pgr_stream_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, TIMEOUT=16
    logic [1:0]  a_valid, a_last, a_ready;
    logic [15:0] a_data;
    logic        a_ovalid, a_olast, a_oready, a_busy, a_err;
    logic [7:0]  a_odata;
    logic [0:0]  a_gid;

    // Instance B: N=2, TIMEOUT=4
    logic [1:0]  b_valid, b_last, b_ready;
    logic [15:0] b_data;
    logic        b_ovalid, b_olast, b_oready, b_busy, b_err;
    logic [7:0]  b_odata;
    logic [0:0]  b_gid;

    // Instance C: N=4, watchdog disabled
    logic [3:0]  c_valid, c_last, c_ready;
    logic [31:0] c_data;
    logic        c_ovalid, c_olast, c_oready, c_busy, c_err;
    logic [7:0]  c_odata;
    logic [1:0]  c_gid;

    pgr_stream_arb #(.N(2), .W(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
        .req_ready(a_ready), .out_valid(a_ovalid), .out_data(a_odata), .out_last(a_olast),
        .out_ready(a_oready), .grant_id(a_gid), .busy(a_busy), .err_timeout(a_err));

    pgr_stream_arb #(.N(2), .W(8), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .out_valid(b_ovalid), .out_data(b_odata), .out_last(b_olast),
        .out_ready(b_oready), .grant_id(b_gid), .busy(b_busy), .err_timeout(b_err));

    pgr_stream_arb #(.N(4), .W(8), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_data(c_data), .req_last(c_last),
        .req_ready(c_ready), .out_valid(c_ovalid), .out_data(c_odata), .out_last(c_olast),
        .out_ready(c_oready), .grant_id(c_gid), .busy(c_busy), .err_timeout(c_err));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packet source model for instance A: requester i emits len[i] beats,
    // data base[i]+pos, last on every plen[i]-th beat.
    int          pos [2];
    int          len [2];
    int          plen[2];
    logic [7:0]  base[2];
    logic [1:0]  acc;
    logic [8:0]  dlv[$];
    logic        prev_busy;

    task automatic a_load(input int l0, input int p0, input logic [7:0] b0,
                          input int l1, input int p1, input logic [7:0] b1);
        pos[0] = 0; len[0] = l0; plen[0] = p0; base[0] = b0;
        pos[1] = 0; len[1] = l1; plen[1] = p1; base[1] = b1;
        acc = '0;
        a_valid = '0;
        a_last = '0;
        dlv.delete();
    endtask

    task automatic a_step(input logic oready);
        @(negedge clk);
        for (int i = 0; i < 2; i++) if (acc[i]) pos[i]++;
        for (int i = 0; i < 2; i++) begin
            a_valid[i]        = (pos[i] < len[i]);
            a_data[i*8 +: 8]  = base[i] + 8'(pos[i]);
            a_last[i]         = (pos[i] < len[i]) && ((pos[i] % plen[i]) == plen[i] - 1);
        end
        a_oready = oready;
        #1;
        acc = a_valid & a_ready;
        if (a_ovalid && a_oready) dlv.push_back({a_olast, a_odata});
    endtask

    function automatic logic [31:0] a_obs();
        return a_ovalid ? {22'b0, 1'b1, a_olast, a_odata} : 32'd0;
    endfunction

    logic [31:0] t1_exp[18] = '{32'h0, 32'h0, 32'h200, 32'h201, 32'h302, 32'h0,
                                32'h210, 32'h211, 32'h312, 32'h0,
                                32'h203, 32'h204, 32'h305, 32'h0,
                                32'h213, 32'h214, 32'h315, 32'h0};
    logic [31:0] t1_gnt[4]  = '{32'd0, 32'd1, 32'd0, 32'd1};
    logic [31:0] t2_exp[5]  = '{32'h0, 32'h0, 32'h2A1, 32'h3A2, 32'h0};
    logic [31:0] rr_exp[6]  = '{32'h0, 32'h0, 32'h350, 32'h0, 32'h360, 32'h0};
    logic [31:0] t3_exp[12] = '{32'h0, 32'h0, 32'h220, 32'h221, 32'h221, 32'h221,
                                32'h221, 32'h221, 32'h221, 32'h222, 32'h323, 32'h0};
    logic [8:0]  t3_dlv[4]  = '{9'h020, 9'h021, 9'h022, 9'h123};
    logic [31:0] t5_gnt[5]  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    logic [31:0] t5_dat[5]  = '{32'h3C0, 32'h3C1, 32'h3C2, 32'h3C3, 32'h3C0};

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int gi;
        a_load(0, 1, 8'h0, 0, 1, 8'h0);
        a_data = '0; a_oready = 1'b1;
        b_valid = '0; b_last = '0; b_data = '0; b_oready = 1'b1;
        c_valid = '0; c_last = '0; c_data = '0; c_oready = 1'b1;

        // Reset values
        #12;
        check("rst_a_ctrl", 32'({a_ovalid, a_olast, a_busy, a_err, a_ready, a_gid}), 32'd0);
        check("rst_a_data", 32'(a_odata), 32'd0);
        check("rst_b_ctrl", 32'({b_ovalid, b_olast, b_busy, b_err, b_ready, b_gid}), 32'd0);
        check("rst_c_ctrl", 32'({c_ovalid, c_olast, c_busy, c_err, c_ready, c_gid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two 3-beat-packet streams, alternating grants with one bubble
        a_load(6, 3, 8'h00, 6, 3, 8'h10);
        prev_busy = 1'b0;
        gi = 0;
        for (int k = 0; k < 18; k++) begin
            a_step(1'b1);
            check("t1_out", a_obs(), t1_exp[k]);
            if (a_busy && !prev_busy) begin
                if (gi < 4) check("t1_grant", 32'(a_gid), t1_gnt[gi]);
                gi++;
            end
            prev_busy = a_busy;
        end
        check("t1_grant_count", 32'(gi), 32'd4);

        // Requester 1 alone, A1 then A2(last)
        a_load(0, 1, 8'h0, 2, 2, 8'hA1);
        for (int k = 0; k < 5; k++) begin
            a_step(1'b1);
            check("t2_out", a_obs(), t2_exp[k]);
        end
        check("t2_dlv_count", 32'(dlv.size()), 32'd2);

        // rr_ptr wrapped to 0: simultaneous single beats serve 0 first
        a_load(1, 1, 8'h50, 1, 1, 8'h60);
        for (int k = 0; k < 6; k++) begin
            a_step(1'b1);
            check("rr_out", a_obs(), rr_exp[k]);
            if (k == 1) check("rr_first_grant", 32'({a_busy, a_gid}), 32'h2);
        end

        // Backpressure: out_ready low for 5 cycles mid-packet
        a_load(4, 4, 8'h20, 0, 1, 8'h0);
        for (int k = 0; k < 12; k++) begin
            a_step(!(k >= 3 && k <= 7));
            check("t3_out", a_obs(), t3_exp[k]);
            if (k >= 3 && k <= 7) check("t3_ready_stall", 32'(a_ready), 32'd0);
        end
        check("t3_dlv_count", 32'(dlv.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < dlv.size()) check("t3_dlv", 32'(dlv[i]), 32'(t3_dlv[i]));

        // Watchdog on instance B
        @(negedge clk);
        b_valid = 2'b11; b_data = {8'h40, 8'h30}; b_last = 2'b10;
        @(negedge clk); #1;
        check("t4_grant", 32'({b_busy, b_gid, b_ready}), 32'b1001);
        @(negedge clk);
        b_valid = 2'b10;
        #1;
        check("t4_beat", 32'({b_ovalid, b_olast, b_odata}), 32'h230);
        check("t4_err_early", 32'(b_err), 32'd0);
        for (int s = 3; s <= 5; s++) begin
            @(negedge clk); #1;
            check("t4_wait", 32'({b_busy, b_err}), 32'b10);
        end
        @(negedge clk); #1;
        check("t4_err_pulse", 32'({b_err, b_busy, b_ready}), 32'b1000);
        @(negedge clk); #1;
        check("t4_regrant", 32'({b_err, b_busy, b_gid, b_ready}), 32'b01110);
        @(negedge clk);
        b_valid = '0;
        #1;
        check("t4_other_beat", 32'({b_ovalid, b_olast, b_odata, b_busy, b_err}), 32'({2'b11, 8'h40, 2'b00}));

        // Four-way round robin, single-beat packets
        @(negedge clk);
        c_valid = 4'hF; c_last = 4'hF; c_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk); #1;
            if (s % 2 == 1) check("t5_grant", 32'({c_busy, c_gid}), 32'h4 | t5_gnt[(s-1)/2]);
            else check("t5_out", 32'({c_ovalid, c_olast, c_odata}), t5_dat[s/2-1]);
        end
        @(negedge clk);
        c_valid = '0;

        // Reset mid-packet on requester 1
        a_load(0, 1, 8'h0, 6, 6, 8'h70);
        for (int k = 0; k < 4; k++) begin
            a_step(1'b1);
            if (k == 1) check("t6_grant", 32'({a_busy, a_gid}), 32'h3);
            if (k == 3) check("t6_midpkt", a_obs(), 32'h271);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 32'({a_ovalid, a_olast, a_busy, a_err, a_ready, a_gid}), 32'd0);
        check("t6_rst_data", 32'(a_odata), 32'd0);
        a_load(1, 1, 8'h80, 1, 1, 8'h90);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_step(1'b1);
            if (k == 1) check("t6_first_grant", 32'({a_busy, a_gid}), 32'h2);
            if (k == 2) check("t6_first_out", a_obs(), 32'h380);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pgr_stream_arb.md
# pgr_stream_arb

Packet-level round-robin arbiter that shares one valid/ready byte stream, normally the input of the shared prefetch FIFO in the uart2apb path, between N requesters. It locks the grant to one requester from its first beat until its `last` beat, so packets never interleave. It drives a one-deep registered output stage. A watchdog releases a grant held by a stalled requester.

## Interface
- `N`, 2: number of requesters, 2..8.
- `W`, 8: data width per beat, 1..256.
- `TIMEOUT`, 256: idle cycles allowed mid-packet before forced release. 0 disables the watchdog.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low. Clock is `clk`.
- `req_valid` input N: per-requester beat valid.
- `req_data` input N*W: requester i occupies bits [i*W +: W].
- `req_last` input N: final beat of the packet.
- `req_ready` output N: beat accepted from requester i.
- `out_valid` output 1: registered output beat valid.
- `out_data` output W: registered output data.
- `out_last` output 1: registered output last flag.
- `out_ready` input 1: downstream accepts (the FIFO's ~full).
- `grant_id` output clog2(N): current/last granted requester.
- `busy` output 1: state is LOCK.
- `err_timeout` output 1: one-cycle pulse on watchdog release.

## Operation
- Registered state: FSM {IDLE, LOCK}, `grant_id`, round-robin pointer `rr_ptr`, output register (`out_valid`, `out_data`, `out_last`), watchdog counter `wd_cnt` (clog2(TIMEOUT+1) bits).
- Load-enable of the output register: `ld = ~out_valid | out_ready`.
- `req_ready[i] = (state==LOCK) & (grant_id==i) & ld`. All other bits are 0.
- Transfer: `xfer = req_valid[grant_id] & req_ready[grant_id]`.
- On `xfer`, the output register loads data and last, and `out_valid` is set.
- If there is no `xfer` and `out_ready` is high, `out_valid` is cleared.
- IDLE:
  - If any `req_valid` is high, grant the first requester with `req_valid` high, searching from `rr_ptr` upward, modulo N.
  - Register it into `grant_id` and go to LOCK. No beat transfers in IDLE.
  - If no `req_valid` is high, stay in IDLE.
- LOCK:
  - On `xfer` with `req_last`: `rr_ptr <= grant_id+1` (wrapping N-1 -> 0), then go to IDLE.
  - On `xfer` without `req_last`: stay in LOCK and clear `wd_cnt`.
- Watchdog (TIMEOUT>0):
  - In LOCK, `wd_cnt` increments on every cycle without `xfer` and is cleared on `xfer` or entry into LOCK.
  - When `wd_cnt` reaches TIMEOUT-1 without `xfer`: pulse `err_timeout` next cycle, go to IDLE, and set `rr_ptr <= grant_id+1`.
  - The output register is not altered. The downstream sees a truncated packet, with no `out_last`.
- Backpressure: while `out_valid & ~out_ready`, `req_ready` is 0 and the output register holds. `wd_cnt` still counts.
- A grant is never given to a requester whose `req_valid` is low at the arbitration cycle.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `wd_cnt` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `err_timeout` 0, `req_ready` all 0.
- Reset asserted mid-packet aborts immediately; there are no partial-beat side effects after reset.
- Arbitration costs exactly one bubble cycle per packet: IDLE->LOCK, then the first beat can be accepted in the cycle after the grant.
- Input to output latency is 1 cycle: a beat accepted at edge k has `out_valid` high after edge k.
- Sustained throughput is 1 beat/cycle within a packet when `out_ready` is held 1.
- Single-beat packets: grant, 1 beat, then back to IDLE. The peak rate is therefore 1 packet every 2 cycles.
- `req_valid` dropping mid-packet does not release the grant; only `last` or the watchdog does.
- Simultaneous requests are resolved strictly by `rr_ptr`. Requester `rr_ptr` itself has top priority.
- `busy` and `grant_id` are registered, with no combinational path from inputs.
- `req_ready` depends combinationally on `out_ready` only.

## Test plan
- N=2, both requesters send a 3-beat packet continuously with out_ready=1 -> output is 0,0,0 then 1,1,1 (tagged by grant_id), with one bubble per packet; grant order alternates 0,1,0,1.
- Requester 1 alone sends packets of data 0xA1,0xA2(last) -> the first `out_valid` rises 2 cycles after `req_valid`; `out_last` is high on 0xA2; `rr_ptr` becomes 0.
- Hold out_ready=0 for 5 cycles mid-packet -> `req_ready` stays 0, `out_data` holds, and no beat is lost or duplicated after release.
- TIMEOUT=4, the granted requester stops after beat 1 without last -> `err_timeout` pulses once, 4 cycles after the last xfer; then `busy`=0 and the other requester is granted.
- N=4, all valid, single-beat packets -> grant sequence 0,1,2,3,0 (rr_ptr wraps 3->0).
- Assert rst_n low mid-packet -> all outputs return to reset values at once; after release the first grant goes to requester 0.
